// File: rtl/regfile_nr2w1_pkg.sv
// Shared register-file constants and the architectural register address type
// used by decode and writeback.
package regfile_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int ZERO_REG  = 0;
  localparam int REG_AW    = $clog2(REG_DEPTH);

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_nr2w1_if.sv
// Register-file access bundle: two read ports with pending flags, one strobed
// write port and the decode-side allocate request.
interface regfile_nr2w1_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  // No handshake: reads and pending flags are combinational from the address
  // and stored state; a write or alloc takes effect on the clock edge where it
  // is asserted, with no back-pressure.
  logic [AW-1:0]      ra1;
  logic [AW-1:0]      ra2;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic               we;
  logic [AW-1:0]      wa;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH/8-1:0] wstrb;
  logic               alloc;
  logic [AW-1:0]      alloc_addr;
  logic               pend1;
  logic               pend2;

  modport master (
    output ra1, ra2, we, wa, wd, wstrb, alloc, alloc_addr,
    input  rd1, rd2, pend1, pend2
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, wstrb, alloc, alloc_addr,
    output rd1, rd2, pend1, pend2
  );
endinterface

// File: rtl/regfile_nr2w1_reg_word_en.sv
// One register word with synchronous clear and independent byte-lane enables.
module reg_word_en #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int k = 0; k < WIDTH/8; k++) begin
        if (be[k]) q[8*k +: 8] <= d[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/regfile_nr2w1.sv
// Architectural register file: r0 hardwired to zero, two combinational read
// ports with optional write forwarding, and a per-register pending scoreboard.
module regfile_nr2w1
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_DEPTH,
  parameter int BYPASS = 1
) (
  input logic            clk,
  input logic            reset,
  regfile_nr2w1_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             hit1;
  logic             hit2;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_word
      logic [NB-1:0] be;
      assign be = (bus.we && (bus.wa == AW'(i))) ? bus.wstrb : '0;
      reg_word_en #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .reset (reset),
        .be    (be),
        .d     (bus.wd),
        .q     (mem[i])
      );
    end
  end

  // The later assignment wins, so an alloc overrides a same-cycle clear and
  // bit 0 can never become pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (bus.we)    pending[bus.wa]         <= 1'b0;
      if (bus.alloc) pending[bus.alloc_addr] <= 1'b1;
      pending[ZERO_REG] <= 1'b0;
    end
  end

  assign hit1 = (BYPASS != 0) && bus.we && (bus.wa == bus.ra1) && (bus.ra1 != '0);
  assign hit2 = (BYPASS != 0) && bus.we && (bus.wa == bus.ra2) && (bus.ra2 != '0);

  always_comb begin
    bus.rd1 = mem[bus.ra1];
    bus.rd2 = mem[bus.ra2];
    for (int k = 0; k < NB; k++) begin
      if (hit1 && bus.wstrb[k]) bus.rd1[8*k +: 8] = bus.wd[8*k +: 8];
      if (hit2 && bus.wstrb[k]) bus.rd2[8*k +: 8] = bus.wd[8*k +: 8];
    end
  end

  // A forwarded value is already the producer's result, so it is not pending.
  assign bus.pend1 = pending[bus.ra1] && !hit1;
  assign bus.pend2 = pending[bus.ra2] && !hit2;

endmodule

// File: doc/regfile_nr2w1.md
# regfile_nr2w1

Parametrised multi-entry register file for the MIPS datapath: a bank of `DEPTH` registers of `WIDTH` bits with two combinational read ports, one write port with byte-lane strobes, a hardwired-zero register 0, and a per-register pending scoreboard for hazard detection. It generalises the single 32-bit clearable register into the processor's architectural register file. It sits between decode (read/allocate) and writeback (write/clear).

## Interface
Parameters:
- `WIDTH`, 32, data bits per register; a multiple of 8.
- `DEPTH`, 32, number of registers; a power of two, at least 2.
- `BYPASS`, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only.
- `AW`, derived, $clog2(DEPTH), register address width.

Ports, with clock and reset first:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `ra1`  in  AW  read address, port 1.
- `rd1`  out  WIDTH  read data, port 1.
- `ra2`  in  AW  read address, port 2.
- `rd2`  out  WIDTH  read data, port 2.
- `we`  in  1  write enable.
- `wa`  in  AW  write address.
- `wd`  in  WIDTH  write data.
- `wstrb`  in  WIDTH/8  byte-lane write strobes; bit i covers `wd[8i+7:8i]`.
- `alloc`  in  1  mark `alloc_addr` as pending; issued by decode.
- `alloc_addr`  in  AW  register being allocated.
- `pend1`  out  1  register `ra1` is pending.
- `pend2`  out  1  register `ra2` is pending.

## Operation
Reset:
- On a clock edge with `reset`=1, all registers are cleared to 0 and all pending bits are cleared.
- `we` and `alloc` are ignored in that cycle.
- After reset, `rd1`=`rd2`=0 and `pend1`=`pend2`=0 for any address.

Write:
- When `we`=1 and `wa`≠0, each byte lane with `wstrb[i]`=1 takes `wd` at the clock edge.
- Lanes with a zero strobe keep their old value.
- `we`=1 with `wstrb`=0 changes no data but still clears the pending bit.

Register 0:
- Always reads 0, whatever has been written to it.
- A write to register 0 has no effect.
- `alloc` of register 0 is ignored, so it is never pending.

Read (combinational):
- `rdN` = contents of register `raN`.
- If `BYPASS`=1, and `we`=1, and `wa`=`raN`≠0: the strobed lanes of `rdN` come from `wd` and the other lanes from stored contents.

Scoreboard (`pending[DEPTH-1:1]`):
- `alloc`=1 sets `pending[alloc_addr]`.
- `we`=1 clears `pending[wa]`.
- If `alloc` and `we` target the same register in the same cycle, **the set wins**: a new producer has issued.
- `pendN` = `pending[raN]`, except as below.
- If `BYPASS`=1 and a same-cycle write targets `raN`, `pendN`=0, because the value is being forwarded.
- Allocating a register that is already pending keeps it pending; there is no error and no count.

## Timing
- Write latency: 1 cycle. Data is visible on the read ports in the cycle after the edge, or in the same cycle when `BYPASS`=1.
- Read latency: 0 cycles. Reads are purely combinational from addresses and stored state.
- `pendN` updates in the cycle after `alloc`/`we`, apart from the same-cycle bypass override.
- Reset asserted mid-operation clears everything at that edge; in-flight pending bits are lost.
- Reset has priority over `we` and `alloc`.
- Both read ports may address the same register, or the register being written; both return identical data.
- No output may depend on `reset` combinationally. Only the stored state is reset.

## Structure
- Shared package `regfile_pkg`:
  - `REG_WIDTH`=32, `REG_DEPTH`=32, `ZERO_REG`=0.
  - A typedef `reg_addr_t` (logic [4:0]) used by decode and writeback.
- Sub-module `reg_word_en`:
  - One `WIDTH`-bit register with synchronous active-high `reset` and per-byte enables.
  - Instantiated for registers 1..DEPTH-1 in a generate loop.
  - Register 0 is a constant, not storage.
- The scoreboard is a flat `DEPTH`-bit vector in the top module; bit 0 is tied to 0.
- Read muxes and bypass logic sit in the top module.

## Test plan
- Reset, then read every address on both ports: all `rd`=0 and all `pend`=0. Write 0xDEADBEEF to r5, assert `reset` with `we`=1 for a further write in the same cycle: r5 reads 0 afterwards.
- Write 0x12345678 to r0, then read r0: `rd1`=0. `alloc` r0: `pend1`=0.
- Write 0xAABBCCDD to r7 with `wstrb`=1111, then 0x11223344 with `wstrb`=0101: r7 reads 0xAA22CC44.
- With `BYPASS`=1, write 0xCAFEF00D to r9 while `ra1`=`ra2`=9: both read 0xCAFEF00D in the same cycle. With `BYPASS`=0, the old value shows in that cycle and the new value in the next.
- `alloc` r3, so `pend1` for `ra1`=3 is 1 in the next cycle. `we` r3 with data 0x42: `pend1`=0, `rd1`=0x42.
- Same cycle `alloc`=r4 and `we` to r4: afterwards r4 holds the new data and `pend` for r4 is 1. A later `we` to r4 clears it.
